// File: rtl/tt10_pkg.sv
// Shared width and reference XOR/shift function for the tt10 XOR-shift block.
package tt10_pkg;

    localparam int WIDTH = 8;

    function automatic logic [WIDTH-1:0] xor_shift(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] x;
        x = a ^ b;
        return a[WIDTH-1] ? {x[WIDTH-2:0], 1'b0} : x;
    endfunction

endpackage

// File: rtl/tt10_xor_shift_core.sv
// Combinational datapath: XOR of the operands, then a one-bit left shift selected by A's MSB.
module tt10_xor_shift_core
    import tt10_pkg::*;
#(
    parameter int WIDTH = tt10_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y
);

    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_shl;
    logic             w_sel;

    assign w_x   = i_a ^ i_b;
    // Shift is keyed on operand A only, never on B or the XOR result.
    assign w_sel = i_a[WIDTH-1];

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shl
            if (gi == 0) begin : g_lsb
                assign w_shl[gi] = 1'b0;
            end else begin : g_upper
                assign w_shl[gi] = w_x[gi-1];
            end
        end
    endgenerate

    assign o_y = w_sel ? w_shl : w_x;

endmodule

// File: rtl/tt10_xor_shift.sv
// Top: registers the XOR/shift result every clock; synchronous active-high reset clears it.
module tt10_xor_shift
    import tt10_pkg::*;
#(
    parameter int WIDTH = tt10_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ui_in,
    input  logic [WIDTH-1:0] uio_in,
    output logic [WIDTH-1:0] uo_out
);

    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] r_out;

    tt10_xor_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_a (ui_in),
        .i_b (uio_in),
        .o_y (w_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
        end else begin
            r_out <= w_next;
        end
    end

    assign uo_out = r_out;

endmodule

// File: tb/tb_tt10_xor_shift.sv
// Self-checking bench: directed literal vectors plus 1000 random vectors against an arithmetic model.
module tb_tt10_xor_shift;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_out;
    logic       chk_en = 1'b0;

    tt10_xor_shift dut (
        .clk    (clk),
        .rst    (rst),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out)
    );

    always #5 clk = ~clk;

    // Plain arithmetic: XOR, then doubling modulo 256 when A is 128 or more.
    function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b);
        int x;
        x = int'(a ^ b);
        if (int'(a) >= 128) x = (x * 2) % 256;
        return x[7:0];
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h (a=%02h b=%02h rst=%0b) t=%0t",
                     name, act, exp, ui_in, uio_in, rst, $time);
        end
    endtask

    // Expected register content after each edge.
    always @(posedge clk) begin
        exp_out = rst ? 8'h00 : model(ui_in, uio_in);
        chk_en  = 1'b1;
    end

    // Cycle-by-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) check("cycle", uo_out, exp_out);
    end

    task automatic apply(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp, input string name);
        @(negedge clk);
        ui_in  = a;
        uio_in = b;
        @(posedge clk);
        #1;
        check(name, uo_out, exp);
        $display("vec %s: a=%02h b=%02h -> uo_out=%02h", name, a, b, uo_out);
    endtask

    initial begin
        rst    = 1'b1;
        ui_in  = 8'($urandom);
        uio_in = 8'($urandom);

        // Pin the model itself against hand-computed results.
        check("model_55_33", model(ui_in ^ ui_in ^ 8'h55, 8'h33), 8'h66);
        check("model_D5_33", model(8'hD5, uio_in ^ uio_in ^ 8'h33), 8'hCC);
        check("model_80_01", model(ui_in ^ ui_in ^ 8'h80, 8'h01), 8'h02);

        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", uo_out, 8'h00);
            $display("reset edge %0d: uo_out=%02h", i, uo_out);
            ui_in  = 8'($urandom);
            uio_in = 8'($urandom);
        end

        @(negedge clk);
        rst = 1'b0;
        apply(8'h55, 8'h33, 8'h66, "no_shift");
        apply(8'hD5, 8'h33, 8'hCC, "shift_msb_drop");
        apply(8'hFF, 8'hFF, 8'h00, "shift_zero");
        apply(8'h80, 8'h01, 8'h02, "shift_81");
        apply(8'h00, 8'h80, 8'h80, "sel_from_a_only");
        apply(8'h7F, 8'h80, 8'hFF, "x_msb_no_shift");
        apply(8'hC0, 8'h40, 8'h00, "x_msb_dropped");

        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            ui_in  = 8'($urandom);
            uio_in = 8'($urandom);
            rst    = (i >= 500 && i < 502) || ($urandom_range(0, 99) == 0);
            if (i == 500) begin
                @(posedge clk);
                #1;
                check("midrun_reset", uo_out, 8'h00);
                $display("mid-run reset: uo_out=%02h", uo_out);
            end
        end

        @(negedge clk);
        rst = 1'b0;
        apply(8'hD5, 8'h33, 8'hCC, "resume");
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
